// File: rtl/dual_out_checker.sv
// dual_out_checker
//   Aligns two result streams (A = reference model, B = RTL under test) through
//   one small FIFO per stream. It pops one entry from each FIFO whenever both
//   hold data, and registers a pair comparison on {bool,data}. Match and
//   mismatch counts saturate. The comparison index wraps. The error and
//   overflow flags stay set until rstn or clear.
//
//   Optional feature macro: DIFF_CAPTURE_EN. When it is defined, the module
//   also captures the first mismatching pair and its index after reset/clear.
//
// Ports
//   clk                  single clock, rising edge
//   rstn                 asynchronous active-low reset
//   a_valid/b_valid      sample present on stream A / B
//   a_bool/b_bool        boolean result of each stream
//   a_data/b_data        data result of each stream (DATA_WIDTH)
//   clear                synchronous clear of FIFOs, counters and sticky flags
//   cmp_valid            one-cycle pulse per completed comparison
//   mismatch             qualifies cmp_valid: the pair differed
//   err_sticky           set on any mismatch
//   overflow             set when a sample is dropped on a full FIFO
//   match_cnt/mism_cnt   saturating pair counters (CNT_WIDTH)
//   cmp_idx              1-based index of the last comparison, wrapping
//   first_a/first_b      (DIFF_CAPTURE_EN) first mismatching {bool,data} pair
//   first_idx            (DIFF_CAPTURE_EN) cmp_idx of that pair
module dual_out_checker #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  a_valid,
  input  logic                  a_bool,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  b_valid,
  input  logic                  b_bool,
  input  logic [DATA_WIDTH-1:0] b_data,
  input  logic                  clear,
  output logic                  cmp_valid,
  output logic                  mismatch,
  output logic                  err_sticky,
  output logic                  overflow,
  output logic [CNT_WIDTH-1:0]  match_cnt,
  output logic [CNT_WIDTH-1:0]  mism_cnt,
  output logic [CNT_WIDTH-1:0]  cmp_idx
`ifdef DIFF_CAPTURE_EN
  ,
  output logic [DATA_WIDTH:0]   first_a,
  output logic [DATA_WIDTH:0]   first_b,
  output logic [CNT_WIDTH-1:0]  first_idx
`endif
);

  localparam int EW = DATA_WIDTH + 1;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]          PTR_ONE = (AW+1)'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // The pointers carry one extra wrap bit so that a full FIFO and an empty
  // FIFO can be told apart.
  logic [EW-1:0] mem_a [DEPTH];
  logic [EW-1:0] mem_b [DEPTH];
  logic [AW:0]   wr_a, rd_a, wr_b, rd_b;

  logic          empty_a, empty_b, full_a, full_b;
  logic          pop, push_a, push_b, drop;
  logic [EW-1:0] head_a, head_b;
  logic          diff;

  assign empty_a = (wr_a == rd_a);
  assign empty_b = (wr_b == rd_b);
  assign full_a  = (wr_a[AW-1:0] == rd_a[AW-1:0]) && (wr_a[AW] != rd_a[AW]);
  assign full_b  = (wr_b[AW-1:0] == rd_b[AW-1:0]) && (wr_b[AW] != rd_b[AW]);

  assign pop     = !empty_a && !empty_b;
  // A push to a full FIFO is still accepted when the same edge frees a slot.
  assign push_a  = a_valid && (!full_a || pop);
  assign push_b  = b_valid && (!full_b || pop);
  assign drop    = (a_valid && full_a && !pop) || (b_valid && full_b && !pop);

  assign head_a  = mem_a[rd_a[AW-1:0]];
  assign head_b  = mem_b[rd_b[AW-1:0]];
  assign diff    = (head_a != head_b);

  // Stage 0: FIFO storage (data only, no reset)
  always_ff @(posedge clk) begin
    if (push_a) mem_a[wr_a[AW-1:0]] <= {a_bool, a_data};
    if (push_b) mem_b[wr_b[AW-1:0]] <= {b_bool, b_data};
  end

  // Stage 1: pointers, registered compare result, counters and flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_a       <= '0;
      rd_a       <= '0;
      wr_b       <= '0;
      rd_b       <= '0;
      cmp_valid  <= 1'b0;
      mismatch   <= 1'b0;
      err_sticky <= 1'b0;
      overflow   <= 1'b0;
      match_cnt  <= '0;
      mism_cnt   <= '0;
      cmp_idx    <= '0;
`ifdef DIFF_CAPTURE_EN
      first_a    <= '0;
      first_b    <= '0;
      first_idx  <= '0;
`endif
    end else if (clear) begin
      wr_a       <= '0;
      rd_a       <= '0;
      wr_b       <= '0;
      rd_b       <= '0;
      cmp_valid  <= 1'b0;
      mismatch   <= 1'b0;
      err_sticky <= 1'b0;
      overflow   <= 1'b0;
      match_cnt  <= '0;
      mism_cnt   <= '0;
      cmp_idx    <= '0;
`ifdef DIFF_CAPTURE_EN
      first_a    <= '0;
      first_b    <= '0;
      first_idx  <= '0;
`endif
    end else begin
      if (push_a) wr_a <= wr_a + PTR_ONE;
      if (push_b) wr_b <= wr_b + PTR_ONE;
      if (pop) begin
        rd_a <= rd_a + PTR_ONE;
        rd_b <= rd_b + PTR_ONE;
      end
      cmp_valid <= pop;
      mismatch  <= pop && diff;
      if (drop) overflow <= 1'b1;
      if (pop) begin
        cmp_idx <= cmp_idx + CNT_ONE;
        if (diff) begin
          err_sticky <= 1'b1;
          mism_cnt   <= sat_inc(mism_cnt);
        end else begin
          match_cnt  <= sat_inc(match_cnt);
        end
      end
`ifdef DIFF_CAPTURE_EN
      // err_sticky is still low only until the first mismatch, so it marks
      // the pair to capture.
      if (pop && diff && !err_sticky) begin
        first_a   <= head_a;
        first_b   <= head_b;
        first_idx <= cmp_idx + CNT_ONE;
      end
`endif
    end
  end

endmodule

// File: tb/tb_dual_out_checker.sv
module tb_dual_out_checker;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 5;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          a_valid = 1'b0, a_bool = 1'b0, b_valid = 1'b0, b_bool = 1'b0, clear = 1'b0;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic          cmp_valid, mismatch, err_sticky, overflow;
  logic [CW-1:0] match_cnt, mism_cnt, cmp_idx;
`ifdef DIFF_CAPTURE_EN
  logic [DW:0]   first_a, first_b;
  logic [CW-1:0] first_idx;
`endif

  dual_out_checker #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rstn(rstn),
    .a_valid(a_valid), .a_bool(a_bool), .a_data(a_data),
    .b_valid(b_valid), .b_bool(b_bool), .b_data(b_data),
    .clear(clear),
    .cmp_valid(cmp_valid), .mismatch(mismatch), .err_sticky(err_sticky),
    .overflow(overflow), .match_cnt(match_cnt), .mism_cnt(mism_cnt),
    .cmp_idx(cmp_idx)
`ifdef DIFF_CAPTURE_EN
    , .first_a(first_a), .first_b(first_b), .first_idx(first_idx)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          mism;
    logic [CW-1:0] idx;
  } exp_t;

  // Reference model: one queue per stream plus plain state variables.
  exp_t          exp_q[$];
  logic [DW:0]   qa[$];
  logic [DW:0]   qb[$];
  logic [CW-1:0] m_match, m_mism, m_idx, m_first_idx;
  logic          m_err, m_ovf;
  logic [DW:0]   m_first_a, m_first_b;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    exp_q.delete();
    m_match = '0; m_mism = '0; m_idx = '0;
    m_err = 1'b0; m_ovf = 1'b0;
    m_first_a = '0; m_first_b = '0; m_first_idx = '0;
  endtask

  // Applies the effect of the rising edge that just sampled the current inputs.
  task automatic model_step();
    logic [DW:0] ea, eb;
    logic        d;
    exp_t        e;
    if (!rstn || clear) begin
      model_reset();
      return;
    end
    if (qa.size() > 0 && qb.size() > 0) begin
      ea = qa.pop_front();
      eb = qb.pop_front();
      d = (ea != eb);
      m_idx = m_idx + CW'(1);
      if (d) begin
        if (!m_err) begin
          m_first_a = ea; m_first_b = eb; m_first_idx = m_idx;
        end
        m_err = 1'b1;
        if (m_mism != '1) m_mism = m_mism + CW'(1);
      end else if (m_match != '1) begin
        m_match = m_match + CW'(1);
      end
      e.mism = d;
      e.idx  = m_idx;
      exp_q.push_back(e);
    end
    if (a_valid) begin
      if (qa.size() < DEPTH) qa.push_back({a_bool, a_data});
      else m_ovf = 1'b1;
    end
    if (b_valid) begin
      if (qb.size() < DEPTH) qb.push_back({b_bool, b_data});
      else m_ovf = 1'b1;
    end
  endtask

  task automatic drive(input logic av, input logic ab, input logic [DW-1:0] ad,
                       input logic bv, input logic bb, input logic [DW-1:0] bd,
                       input logic clr);
    a_valid = av; a_bool = ab; a_data = ad;
    b_valid = bv; b_bool = bb; b_data = bd;
    clear = clr;
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  // Monitor: pops an expected comparison whenever one is due and checks state.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cmp_valid", 32'(cmp_valid), 32'(1));
      check("mismatch", 32'(mismatch), 32'(e.mism));
      check("cmp_idx_at_cmp", 32'(cmp_idx), 32'(e.idx));
    end else begin
      check("cmp_valid_idle", 32'(cmp_valid), 32'(0));
      check("mismatch_idle", 32'(mismatch), 32'(0));
    end
    check("match_cnt", 32'(match_cnt), 32'(m_match));
    check("mism_cnt", 32'(mism_cnt), 32'(m_mism));
    check("cmp_idx", 32'(cmp_idx), 32'(m_idx));
    check("err_sticky", 32'(err_sticky), 32'(m_err));
    check("overflow", 32'(overflow), 32'(m_ovf));
`ifdef DIFF_CAPTURE_EN
    check("first_a", 32'(first_a), 32'(m_first_a));
    check("first_b", 32'(first_b), 32'(m_first_b));
    check("first_idx", 32'(first_idx), 32'(m_first_idx));
`endif
  end

  initial begin
    logic [DW-1:0] dv;
    logic          bv;
    model_reset();
    idle(2);
    rstn = 1'b1;
    idle(1);

    // Identical streams 0x00..0x0F, both valid every cycle
    for (int i = 0; i < 16; i++) drive(1'b1, i[0], DW'(i), 1'b1, i[0], DW'(i), 1'b0);
    idle(2);
    check("s1_match_cnt", 32'(match_cnt), 32'(16));
    check("s1_mism_cnt", 32'(mism_cnt), 32'(0));
    check("s1_err", 32'(err_sticky), 32'(0));

    // B delayed by 3 cycles; the counter saturates at 31
    for (int t = 0; t < 19; t++)
      drive(t < 16, 1'b0, DW'(t), t >= 3, 1'b0, DW'(t - 3), 1'b0);
    idle(3);
    check("s2_overflow", 32'(overflow), 32'(0));
    check("s2_match_sat", 32'(match_cnt), 32'(31));

    // Fifth pair differs: A 0xC3, B 0x3C
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 8; i++)
      drive(1'b1, 1'b0, (i == 4) ? 8'hC3 : DW'(i), 1'b1, 1'b0, (i == 4) ? 8'h3C : DW'(i), 1'b0);
    idle(2);
    check("s3_mism_cnt", 32'(mism_cnt), 32'(1));
    check("s3_match_cnt", 32'(match_cnt), 32'(7));
    check("s3_err", 32'(err_sticky), 32'(1));
`ifdef DIFF_CAPTURE_EN
    check("s3_first_a", 32'(first_a), 32'h0C3);
    check("s3_first_b", 32'(first_b), 32'h03C);
    check("s3_first_idx", 32'(first_idx), 32'(5));
`endif

    // Clear on the edge where a pop is pending
    drive(1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 8'h55, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    check("s5_cmp_valid", 32'(cmp_valid), 32'(0));
    check("s5_match_cnt", 32'(match_cnt), 32'(0));
    check("s5_err", 32'(err_sticky), 32'(0));
    idle(2);

    // Only A valid for 5 cycles: the fifth sample is dropped
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, DW'(8'hA0 + i), 1'b0, 1'b0, '0, 1'b0);
    idle(1);
    check("s4_overflow", 32'(overflow), 32'(1));
    // The B samples pair with the four stored A samples, not the dropped one
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, '0, 1'b1, 1'b1, DW'(8'hA0 + i), 1'b0);
    idle(3);
    check("s4_match_cnt", 32'(match_cnt), 32'(4));
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);

    // 40 identical pairs: match_cnt saturates and cmp_idx wraps to 8
    for (int i = 0; i < 40; i++) begin
      dv = DW'($urandom);
      bv = 1'($urandom_range(0, 1));
      drive(1'b1, bv, dv, 1'b1, bv, dv, 1'b0);
    end
    idle(2);
    check("s6_match_sat", 32'(match_cnt), 32'(31));
    check("s6_idx_wrap", 32'(cmp_idx), 32'(8));

    // Reset mid-stream with two entries waiting in FIFO A
    drive(1'b1, 1'b0, 8'hAA, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b1, 1'b0, 8'hAB, 1'b0, 1'b0, '0, 1'b0);
    rstn = 1'b0;
    model_reset();
    #1;
    check("s7_rst_match", 32'(match_cnt), 32'(0));
    check("s7_rst_idx", 32'(cmp_idx), 32'(0));
    idle(2);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, DW'(8'h10 + i), 1'b1, 1'b0, DW'(8'h10 + i), 1'b0);
    idle(2);
    check("s7_post_match", 32'(match_cnt), 32'(4));
    check("s7_post_mism", 32'(mism_cnt), 32'(0));

    // Random traffic with occasional clears
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), DW'($urandom_range(0, 3)),
            $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), DW'($urandom_range(0, 3)),
            $urandom_range(0, 79) == 0);
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
